// File: rtl/writeback_buffer.sv
// writeback_buffer
// In-order buffer for register-file write requests. Requests are queued in a
// small circular FIFO and drained one per cycle into the single register bank
// write port whenever that port is not stalled. Operand reads can look into the
// buffer (youngest entry first) to see values that are not yet written.
// Destination register 0 is never buffered, so it is never written or forwarded.

module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_rd,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         wb_stall,
    output logic                         wb_write,
    output logic [ADDR_W-1:0]            wb_rd,
    output logic [DATA_W-1:0]            wb_data,
    input  logic [ADDR_W-1:0]            rs1,
    input  logic [ADDR_W-1:0]            rs2,
    output logic                         fwd1_hit,
    output logic [DATA_W-1:0]            fwd1_data,
    output logic                         fwd2_hit,
    output logic [DATA_W-1:0]            fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_RD = {ADDR_W{1'b0}};

    logic [ADDR_W-1:0] rd_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              fwd1_hit_s;
    logic              fwd2_hit_s;
    logic [DATA_W-1:0] fwd1_data_s;
    logic [DATA_W-1:0] fwd2_data_s;
    logic [PTR_W-1:0]  slot_s;

    // Handshake: pop whenever the bank port is free; a full buffer still
    // accepts a push in a cycle it pops. Writes to register 0 are discarded.
    always_comb begin
        empty_s  = (count_r == {CNT_W{1'b0}});
        full_s   = (count_r == DEPTH_C);
        pop_s    = !empty_s && !wb_stall && !reset;
        in_ready = !full_s || pop_s;
        push_s   = in_valid && in_ready && (in_rd != ZERO_RD) && !reset;
    end

    // Head entry drives the register bank port directly from state.
    always_comb begin
        wb_write = pop_s;
        wb_rd    = rd_mem_r[head_r];
        wb_data  = data_mem_r[head_r];
        count    = count_r;
    end

    // Forwarding scan from oldest to youngest so the youngest match wins.
    always_comb begin
        fwd1_hit_s  = 1'b0;
        fwd2_hit_s  = 1'b0;
        fwd1_data_s = {DATA_W{1'b0}};
        fwd2_data_s = {DATA_W{1'b0}};
        slot_s      = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s = head_r + PTR_W'(i);
            if ((CNT_W'(i) < count_r) && (rd_mem_r[slot_s] == rs1)) begin
                fwd1_hit_s  = 1'b1;
                fwd1_data_s = data_mem_r[slot_s];
            end else begin
                fwd1_hit_s  = fwd1_hit_s;
            end
            if ((CNT_W'(i) < count_r) && (rd_mem_r[slot_s] == rs2)) begin
                fwd2_hit_s  = 1'b1;
                fwd2_data_s = data_mem_r[slot_s];
            end else begin
                fwd2_hit_s  = fwd2_hit_s;
            end
        end
    end

    // Register 0 never forwards, and nothing forwards while in reset.
    always_comb begin
        fwd1_hit  = fwd1_hit_s && !reset && (rs1 != ZERO_RD);
        fwd2_hit  = fwd2_hit_s && !reset && (rs2 != ZERO_RD);
        fwd1_data = fwd1_data_s;
        fwd2_data = fwd2_data_s;
    end

    // Pointer and occupancy update; reset discards every pending entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clock) begin
        if (push_s) begin
            rd_mem_r[tail_r]   <= in_rd;
            data_mem_r[tail_r] <= in_data;
        end
    end

endmodule
